// File: rtl/hazard_pkg.sv
// hazard_pkg: state encoding, forwarding selects, stall lengths and counter width for hazard_ctrl
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] STALL_LOAD_USE = 2'd1;
  localparam logic [1:0] STALL_IDEX = 2'd2;
  localparam logic [1:0] STALL_EXMEM = 2'd1;
  localparam int CNT_W = 16;
  function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return we && rd != 5'd0 && rs == rd;
  endfunction
endpackage

// File: rtl/forward_unit.sv
// forward_unit: ALU operand select, EX/MEM over MEM/WB; only built with HAZARD_FWD_EN
`ifdef HAZARD_FWD_EN
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] id_ex_rs1,
  input  logic [4:0] id_ex_rs2,
  input  logic [4:0] ex_mem_rd,
  input  logic [4:0] mem_wb_rd,
  input  logic       ex_mem_regwrite,
  input  logic       mem_wb_regwrite,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);
  assign forward_a = reg_match(id_ex_rs1, ex_mem_rd, ex_mem_regwrite) ? FWD_EXMEM :
                     reg_match(id_ex_rs1, mem_wb_rd, mem_wb_regwrite) ? FWD_MEMWB : FWD_NONE;
  assign forward_b = reg_match(id_ex_rs2, ex_mem_rd, ex_mem_regwrite) ? FWD_EXMEM :
                     reg_match(id_ex_rs2, mem_wb_rd, mem_wb_regwrite) ? FWD_MEMWB : FWD_NONE;
endmodule
`endif

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush FSM with saturating perf counters
// HAZARD_FWD_EN adds forwarding and limits stalls to load-use
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_valid,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             id_ex_regwrite,
  input  logic [4:0]       ex_mem_rd,
  input  logic [4:0]       mem_wb_rd,
  input  logic             ex_mem_regwrite,
  input  logic             mem_wb_regwrite,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
`ifdef HAZARD_FWD_EN
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
`endif
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, len;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  logic idex_hit, stall_now;
  assign idex_hit = reg_match(if_id_rs1, id_ex_rd, id_ex_regwrite) ||
                    reg_match(if_id_rs2, id_ex_rd, id_ex_regwrite);
`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a, fwd_b;
  assign len = (id_ex_memread && idex_hit) ? STALL_LOAD_USE : 2'd0;
  forward_unit u_fwd (
    .id_ex_rs1      (id_ex_rs1),
    .id_ex_rs2      (id_ex_rs2),
    .ex_mem_rd      (ex_mem_rd),
    .mem_wb_rd      (mem_wb_rd),
    .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_regwrite(mem_wb_regwrite),
    .forward_a      (fwd_a),
    .forward_b      (fwd_b)
  );
  assign forward_a = reset_n ? fwd_a : FWD_NONE;
  assign forward_b = reset_n ? fwd_b : FWD_NONE;
`else
  logic exmem_hit, unused_fwd;
  assign exmem_hit = reg_match(if_id_rs1, ex_mem_rd, ex_mem_regwrite) ||
                     reg_match(if_id_rs2, ex_mem_rd, ex_mem_regwrite);
  assign len = idex_hit ? STALL_IDEX : exmem_hit ? STALL_EXMEM : 2'd0;
  // MEM/WB results reach ID through the write-first register file, so no stall or forward
  assign unused_fwd = ^{id_ex_rs1, id_ex_rs2, id_ex_memread, mem_wb_rd, mem_wb_regwrite};
`endif
  always_comb begin
    stall_now = !branch_taken && (state_q == STALL || (state_q == RUN && if_id_valid && len != 2'd0));
    cnt_d = branch_taken ? 2'd0 : state_q == STALL ? cnt_q - 2'd1 : stall_now ? len - 2'd1 : 2'd0;
    state_d = branch_taken ? FLUSH : (stall_now && cnt_d != 2'd0) ? STALL : RUN;
    stall_cycles_d = (stall_now && stall_cycles_q != '1) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
    flush_events_d = (branch_taken && flush_events_q != '1) ? flush_events_q + CNT_W'(1) : flush_events_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q <= 2'd0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end
  // the bubble goes in during the detecting cycle, so outputs decode state and inputs directly
  assign pc_write = reset_n && !stall_now;
  assign if_id_write = reset_n && !stall_now && !branch_taken;
  assign if_id_flush = !reset_n || branch_taken || state_q == FLUSH;
  assign id_ex_flush = !reset_n || branch_taken || stall_now;
  assign ex_mem_flush = !reset_n || branch_taken;
  assign state = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random and directed stimulus against a cycle-level reference model
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic if_id_valid, id_ex_memread, id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite, branch_taken;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] state;
  logic [15:0] stall_cycles, flush_events;
`ifdef HAZARD_FWD_EN
  logic [1:0] forward_a, forward_b;
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif
  int n_vec = 0, n_bad = 0;
  int m_state = 0, m_left = 0, m_stalls = 0, m_flushes = 0;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_valid(if_id_valid),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite),
    .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
    .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
`ifdef HAZARD_FWD_EN
    .forward_a(forward_a), .forward_b(forward_b),
`endif
    .state(state), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return we && rd != 5'd0 && rs == rd;
  endfunction
  function automatic int need_len();
    bit idex = hit(if_id_rs1, id_ex_rd, id_ex_regwrite) || hit(if_id_rs2, id_ex_rd, id_ex_regwrite);
    bit exmem = hit(if_id_rs1, ex_mem_rd, ex_mem_regwrite) || hit(if_id_rs2, ex_mem_rd, ex_mem_regwrite);
    if (FWD != 0) return (id_ex_memread && idex) ? 1 : 0;
    return idex ? 2 : exmem ? 1 : 0;
  endfunction
  function automatic int fwd_sel(input logic [4:0] rs);
    return hit(rs, ex_mem_rd, ex_mem_regwrite) ? 2 : hit(rs, mem_wb_rd, mem_wb_regwrite) ? 1 : 0;
  endfunction
  task automatic step();
    int need = need_len();
    bit brk = branch_taken;
    bit stl;
    @(negedge clk);
    stl = !brk && (m_state == 1 || (m_state == 0 && if_id_valid && need > 0));
    if (!reset_n) begin
      chk("pc_write_rst", pc_write, 0);
      chk("if_id_write_rst", if_id_write, 0);
      chk("flushes_rst", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
`ifdef HAZARD_FWD_EN
      chk("fwd_rst", {forward_a, forward_b}, 4'b0000);
`endif
    end else begin
      chk("pc_write", pc_write, !stl);
      chk("if_id_write", if_id_write, !stl && !brk);
      chk("if_id_flush", if_id_flush, brk || m_state == 2);
      chk("id_ex_flush", id_ex_flush, brk || stl);
      chk("ex_mem_flush", ex_mem_flush, brk);
`ifdef HAZARD_FWD_EN
      chk("forward_a", forward_a, fwd_sel(id_ex_rs1));
      chk("forward_b", forward_b, fwd_sel(id_ex_rs2));
`endif
    end
    chk("state", state, m_state);
    chk("stall_cycles", stall_cycles, m_stalls);
    chk("flush_events", flush_events, m_flushes);
    if (!reset_n) begin
      m_state = 0; m_left = 0; m_stalls = 0; m_flushes = 0;
    end else if (brk) begin
      m_state = 2; m_left = 0;
      m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
    end else if (stl) begin
      m_left = (m_state == 1) ? m_left - 1 : need - 1;
      m_state = (m_left > 0) ? 1 : 0;
      m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
    end else m_state = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    reset_n = 1'b1; branch_taken = 1'b0; if_id_valid = 1'b1;
    {if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
    {id_ex_memread, id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite} = '0;
  endtask
  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask
  task automatic load_hazard(input logic [4:0] r);
    if_id_rs1 = r; id_ex_rd = r; id_ex_regwrite = 1'b1; id_ex_memread = 1'b1;
  endtask
  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset_n = 1'b1;
    // dependent instruction right behind its producer
    load_hazard(5'd6);
    step();
    chk("dep_state1", state, FWD ? 0 : 1);
    id_ex_regwrite = 1'b0; id_ex_memread = 1'b0; ex_mem_rd = 5'd6; ex_mem_regwrite = 1'b1;
    step();
    chk("dep_state2", state, 0);
    chk("dep_stalls", stall_cycles, FWD ? 1 : 2);
    idle();
    id_ex_rd = 5'd0; id_ex_regwrite = 1'b1; id_ex_memread = 1'b1;
    step();
    chk("x0_state", state, 0);
    chk("x0_stalls", stall_cycles, FWD ? 1 : 2);
    // branch in the first cycle of a stall
    do_reset();
    load_hazard(5'd3);
    step();
    branch_taken = 1'b1;
    step();
    chk("br_state", state, 2);
    chk("br_flush_events", flush_events, 1);
    chk("br_stalls", stall_cycles, 1);
    idle();
    step();
    chk("br_back_run", state, 0);
    // forwarding priority
    id_ex_rs1 = 5'd7; ex_mem_rd = 5'd7; mem_wb_rd = 5'd7; ex_mem_regwrite = 1'b1; mem_wb_regwrite = 1'b1;
    step();
`ifdef HAZARD_FWD_EN
    chk("fwd_prio", forward_a, 2);
`endif
    // reset mid-stall
    idle();
    if_id_rs2 = 5'd4; id_ex_rd = 5'd4; id_ex_regwrite = 1'b1; id_ex_memread = 1'b1;
    step();
    reset_n = 1'b0;
    step();
    chk("rst_state", state, 0);
    chk("rst_stalls", stall_cycles, 0);
    idle();
    step();
    chk("rst_release", state, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      if_id_valid = ($urandom_range(0, 7) != 0);
      if_id_rs1 = 5'($urandom_range(0, 7)); if_id_rs2 = 5'($urandom_range(0, 7));
      id_ex_rs1 = 5'($urandom_range(0, 7)); id_ex_rs2 = 5'($urandom_range(0, 7));
      id_ex_rd = 5'($urandom_range(0, 7)); ex_mem_rd = 5'($urandom_range(0, 7));
      mem_wb_rd = 5'($urandom_range(0, 7));
      id_ex_memread = 1'($urandom_range(0, 1));
      id_ex_regwrite = ($urandom_range(0, 3) != 0);
      ex_mem_regwrite = ($urandom_range(0, 3) != 0);
      mem_wb_regwrite = ($urandom_range(0, 3) != 0);
      step();
    end
    // stall counter saturation
    do_reset();
    load_hazard(5'd5);
    for (int i = 0; i < 70000; i++) step();
    chk("stall_sat", stall_cycles, 16'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset; sampled on rising clk.
REQ-003 if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
REQ-004 if_id_valid  in  1  ID holds a real instruction; 0 suppresses hazard detection.
REQ-005 id_ex_rs1, id_ex_rs2, id_ex_rd  in  5 each  register fields latched in ID/EX.
REQ-006 id_ex_memread, id_ex_regwrite  in  1 each  ID/EX control bits.
REQ-007 ex_mem_rd, mem_wb_rd  in  5 each; ex_mem_regwrite, mem_wb_regwrite  in  1 each.
REQ-008 branch_taken  in  1  taken branch resolved in MEM (from EX/MEM).
REQ-009 pc_write, if_id_write  out  1 each  enable PC and IF/ID update.
REQ-010 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  zero the register's control/valid fields.
REQ-011 forward_a, forward_b  out  2 each  ALU operand select (present only with HAZARD_FWD_EN).
REQ-012 state  out  2  current FSM state; stall_cycles, flush_events  out  16 each  performance counters.

Function
REQ-013 FSM states RUN(00), STALL(01), FLUSH(10); state and counters registered; outputs SHALL be combinational decode of state and current inputs (bubble inserted in the detecting cycle).
REQ-014 Match: rs equals nonzero rd with that stage's regwrite=1; rd=x0 never matches.
REQ-015 RUN, no hazard, no branch: pc_write=1, if_id_write=1, all flushes 0.
REQ-016 Hazard in RUN: pc_write=0, if_id_write=0, id_ex_flush=1 this cycle; load remaining-stall counter (REQ-026/027) minus 1; go STALL if result >0, else stay RUN.
REQ-017 STALL: same outputs as REQ-016; decrement counter each cycle; return to RUN when counter reaches 0; no re-detection while in STALL.
REQ-018 branch_taken=1 (any state): if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1, if_id_write=0; counter cleared; next state FLUSH.
REQ-019 Branch wins over hazard and aborts an ongoing STALL in the same cycle.
REQ-020 FLUSH: exactly one cycle, if_id_flush=1, pc_write=1, others as RUN; next RUN (or FLUSH again if branch_taken=1).
REQ-021 if_id_valid=0 SHALL never start a stall.
REQ-022 stall_cycles increments each cycle id_ex_flush=1 due to stall; flush_events increments once per branch_taken cycle; both saturate at 0xFFFF, no wrap.

Reset
REQ-023 While reset_n=0 at a clk edge: state<=RUN, stall counter<=0, stall_cycles<=0, flush_events<=0.
REQ-024 While reset_n=0 outputs forced: pc_write=0, if_id_write=0, all flushes=1, forward_a/b=00.
REQ-025 Reset asserted mid-STALL or mid-FLUSH abandons it; first cycle after release is RUN.

Configuration
REQ-026 HAZARD_FWD_EN defined: forwarding sub-module instantiated; only load-use (id_ex_memread and ID/EX match) stalls, length 1; forward_x=10 on EX/MEM match of id_ex_rsx, else 01 on MEM/WB match, else 00; EX/MEM priority.
REQ-027 HAZARD_FWD_EN undefined: no forward ports; ID/EX match stalls 2 cycles, EX/MEM-only match 1 cycle; MEM/WB covered by register-file write-first bypass, no stall.

Structure
REQ-028 Package hazard_pkg: state encoding, FWD_NONE=00, FWD_MEMWB=01, FWD_EXMEM=10, stall lengths, counter width 16.
REQ-029 Sub-module forward_unit (pure combinational select), instantiated only under HAZARD_FWD_EN.

Verification
REQ-030 Load x5, next add uses x5, FWD_EN on -> one cycle pc_write=0/id_ex_flush=1, stall_cycles=1.
REQ-031 FWD_EN off, add x6 then sub reads x6 -> 2 stall cycles, state 01 then 00; x0 as rd -> no stall.
REQ-032 branch_taken during cycle 1 of a 2-cycle stall -> three flushes=1, state FLUSH, stall aborted, flush_events=1.
REQ-033 FWD_EN on, EX/MEM and MEM/WB both write x7, ID/EX rs1=x7 -> forward_a=10.
REQ-034 reset_n=0 mid-STALL -> next edge state=00, counters 0; outputs per REQ-024 during reset.
REQ-035 Force 70000 stall cycles -> stall_cycles holds 0xFFFF.
